// File: rtl/video_sync_analyzer.sv
`default_nettype none
// video_sync_analyzer: measures line/frame geometry, tracks lock and produces active-area x/y from pixel-rate sync.
// Optional per-frame CRC-16-CCITT over active video, enabled by defining VIDEO_SYNC_ANALYZER_CRC_EN.
module video_sync_analyzer #(
  parameter int HW          = 12,
  parameter int VW          = 11,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic          HSync,
  input  logic          HBlank,
  input  logic          VSync,
  input  logic          VBlank,
  input  logic [7:0]    video,
  output logic [HW-1:0] h_total,
  output logic [HW-1:0] h_active,
  output logic [VW-1:0] v_total,
  output logic [VW-1:0] v_active,
  output logic          locked,
  output logic          de,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   crc
);

  localparam logic [HW-1:0] HMAX   = '1;
  localparam logic [VW-1:0] VMAX   = '1;
  localparam logic [3:0]    LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_MEASURE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t        state;
  logic          hs_prev, hb_prev, vs_prev;
  logic [HW-1:0] hcnt, hact;
  logic [VW-1:0] vcnt, vact;
  logic          line_seen, frame_seen;
  logic [HW-1:0] ref_h;
  logic [VW-1:0] ref_v;
  logic [2:0]    match_cnt;

  logic          hs_rise, hb_rise, vs_rise, de_now;
  logic          line_end, frame_end, geom_same, lose_lock;
  logic [HW-1:0] hcnt_inc, hact_inc, h_total_nxt, h_active_nxt;
  logic [VW-1:0] vcnt_inc, vact_inc, v_total_nxt, v_active_nxt;
  logic [3:0]    match_inc;

  always_comb begin
    hs_rise      = HSync & ~hs_prev;
    hb_rise      = HBlank & ~hb_prev;
    vs_rise      = VSync & ~vs_prev;
    de_now       = ~HBlank & ~VBlank;
    hcnt_inc     = (hcnt == HMAX) ? HMAX : hcnt + 1'b1;
    hact_inc     = (HBlank || hact == HMAX) ? hact : hact + 1'b1;
    line_end     = hs_rise & line_seen;
    h_total_nxt  = line_end ? hcnt_inc : h_total;
    h_active_nxt = line_end ? hact_inc : h_active;
    // A line closing on the same sample as VSync rise belongs to the frame being closed.
    vcnt_inc     = (hs_rise && vcnt != VMAX) ? vcnt + 1'b1 : vcnt;
    vact_inc     = (hs_rise && !VBlank && vact != VMAX) ? vact + 1'b1 : vact;
    frame_end    = vs_rise & frame_seen;
    v_total_nxt  = frame_end ? vcnt_inc : v_total;
    v_active_nxt = frame_end ? vact_inc : v_active;
    geom_same    = (h_total_nxt == ref_h) && (v_total_nxt == ref_v);
    match_inc    = {1'b0, match_cnt} + 4'd1;
    lose_lock    = (state == ST_LOCKED) &&
                   ((line_end && h_total_nxt != ref_h) ||
                    (frame_end && v_total_nxt != ref_v) ||
                    (!hs_rise && hcnt_inc == HMAX));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Previous samples start high so the first samples after reset never look like edges.
      hs_prev    <= 1'b1;
      hb_prev    <= 1'b1;
      vs_prev    <= 1'b1;
      hcnt       <= '0;
      hact       <= '0;
      vcnt       <= '0;
      vact       <= '0;
      line_seen  <= 1'b0;
      frame_seen <= 1'b0;
      h_total    <= '0;
      h_active   <= '0;
      v_total    <= '0;
      v_active   <= '0;
      frame_cnt  <= '0;
      de         <= 1'b0;
      x          <= '0;
      y          <= '0;
      state      <= ST_UNLOCKED;
      locked     <= 1'b0;
      ref_h      <= '0;
      ref_v      <= '0;
      match_cnt  <= '0;
    end else if (ce_pix) begin
      hs_prev  <= HSync;
      hb_prev  <= HBlank;
      vs_prev  <= VSync;
      hcnt     <= hs_rise ? '0 : hcnt_inc;
      hact     <= hs_rise ? '0 : hact_inc;
      vcnt     <= vs_rise ? '0 : vcnt_inc;
      vact     <= vs_rise ? '0 : vact_inc;
      h_total  <= h_total_nxt;
      h_active <= h_active_nxt;
      v_total  <= v_total_nxt;
      v_active <= v_active_nxt;
      if (frame_end)
        frame_cnt <= frame_cnt + 16'd1;
      line_seen  <= lose_lock ? 1'b0 : (line_seen | hs_rise);
      frame_seen <= lose_lock ? 1'b0 : (frame_seen | vs_rise);
      de <= de_now;

      if (hb_rise)
        x <= '0;
      else if (de_now && x != HMAX)
        x <= x + 1'b1;

      if (vs_rise)
        y <= '0;
      else if (hb_rise && !VBlank && y != VMAX)
        y <= y + 1'b1;

      case (state)
        ST_UNLOCKED: begin
          if (frame_end) begin
            ref_h     <= h_total_nxt;
            ref_v     <= v_total_nxt;
            match_cnt <= 3'd1;
            if (LOCK_N <= 4'd1) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end else begin
              state  <= ST_MEASURE;
            end
          end
        end
        ST_MEASURE: begin
          if (frame_end) begin
            if (geom_same) begin
              match_cnt <= match_inc[2:0];
              if (match_inc >= LOCK_N) begin
                state  <= ST_LOCKED;
                locked <= 1'b1;
              end
            end else begin
              ref_h     <= h_total_nxt;
              ref_v     <= v_total_nxt;
              match_cnt <= 3'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (lose_lock) begin
            state     <= ST_UNLOCKED;
            locked    <= 1'b0;
            match_cnt <= '0;
          end
        end
        default: begin
          state  <= ST_UNLOCKED;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef VIDEO_SYNC_ANALYZER_CRC_EN
  logic [15:0] crc_acc, crc_acc_nxt;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i])
        r = {r[14:0], 1'b0} ^ 16'h1021;
      else
        r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    crc_acc_nxt = de_now ? crc_step(crc_acc, video) : crc_acc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_acc <= 16'hFFFF;
      crc     <= '0;
    end else if (ce_pix) begin
      if (vs_rise) begin
        if (frame_seen)
          crc <= crc_acc_nxt;
        crc_acc <= 16'hFFFF;
      end else begin
        crc_acc <= crc_acc_nxt;
      end
    end
  end
`else
  logic unused_video;
  assign unused_video = ^video;
  assign crc = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_sync_analyzer.sv
`default_nettype none
// Bench for video_sync_analyzer: directed synthetic frames checked every cycle against a cumulative-count model.
module tb_video_sync_analyzer;

  localparam int HW   = 12;
  localparam int VW   = 11;
  localparam int LF   = 2;
  localparam int HMAX = 4095;
  localparam int VMAX = 2047;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ce_pix = 1'b0;
  logic          HSync = 1'b0, HBlank = 1'b0, VSync = 1'b0, VBlank = 1'b0;
  logic [7:0]    video = 8'h00;
  logic [HW-1:0] h_total, h_active, x;
  logic [VW-1:0] v_total, v_active, y;
  logic          locked, de;
  logic [15:0]   frame_cnt, crc;

  video_sync_analyzer #(.HW(HW), .VW(VW), .LOCK_FRAMES(LF)) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix),
    .HSync(HSync), .HBlank(HBlank), .VSync(VSync), .VBlank(VBlank), .video(video),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
    .locked(locked), .de(de), .x(x), .y(y), .frame_cnt(frame_cnt), .crc(crc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  bit rnd_vid = 1'b0;

  // Expected outputs
  int e_ht, e_ha, e_vt, e_va, e_fc, e_crc, e_x, e_y;
  bit e_lk, e_de;

  // Model state: absolute sample index plus cumulative event counts; measurements are differences.
  int s, r_h, act_cum, act_rise, lines, vlines, lines_vs, vlines_vs, de_cum, de_hbr, yc, yc_vs;
  bit p_hs, p_hb, p_vs, l_seen, f_seen, m_lk;
  int run, ref_h, ref_v;
  byte unsigned frame_bytes[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic int crc_of(input byte unsigned q[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (q[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ q[i][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return int'(c);
  endfunction

  task automatic model(input bit rst, input bit hs, input bit hb, input bit vs, input bit vb,
                       input logic [7:0] v);
    bit hr, hbr, vr, unl;
    if (rst) begin
      s = 0; r_h = 0; act_cum = 0; act_rise = 0; lines = 0; vlines = 0;
      lines_vs = 0; vlines_vs = 0; de_cum = 0; de_hbr = 0; yc = 0; yc_vs = 0;
      p_hs = 1; p_hb = 1; p_vs = 1; l_seen = 0; f_seen = 0; m_lk = 0;
      run = 0; ref_h = 0; ref_v = 0; frame_bytes.delete();
      e_ht = 0; e_ha = 0; e_vt = 0; e_va = 0; e_fc = 0; e_crc = 0;
      e_x = 0; e_y = 0; e_lk = 0; e_de = 0;
      return;
    end
    hr  = hs && !p_hs;
    hbr = hb && !p_hb;
    vr  = vs && !p_vs;
    p_hs = hs; p_hb = hb; p_vs = vs;
    s++;
    if (!hb) act_cum++;
    e_de = !hb && !vb;
    if (e_de) begin
      de_cum++;
      frame_bytes.push_back(v);
    end
    if (hbr) de_hbr = de_cum;
    e_x = sat(de_cum - de_hbr, HMAX);
    if (hbr && !vb) yc++;
    unl = 0;
    if (hr) begin
      lines++;
      if (!vb) vlines++;
      if (l_seen) begin
        e_ht = sat(s - r_h, HMAX);
        e_ha = sat(act_cum - act_rise, HMAX);
        if (m_lk && e_ht != ref_h) unl = 1;
      end
      r_h = s; act_rise = act_cum; l_seen = 1;
    end else if (m_lk && (s - r_h) >= HMAX) begin
      unl = 1;
    end
    if (vr) begin
      if (f_seen) begin
        e_vt = sat(lines - lines_vs, VMAX);
        e_va = sat(vlines - vlines_vs, VMAX);
        e_fc = (e_fc + 1) % 65536;
`ifdef VIDEO_SYNC_ANALYZER_CRC_EN
        e_crc = crc_of(frame_bytes);
`endif
        if (m_lk) begin
          if (e_vt != ref_v) unl = 1;
        end else begin
          if (run > 0 && e_ht == ref_h && e_vt == ref_v) run++;
          else begin
            run = 1; ref_h = e_ht; ref_v = e_vt;
          end
          if (run >= LF) m_lk = 1;
        end
      end
      lines_vs = lines; vlines_vs = vlines; yc_vs = yc;
      frame_bytes.delete();
      f_seen = 1;
    end
    e_y = sat(yc - yc_vs, VMAX);
    if (unl) begin
      m_lk = 0; run = 0; l_seen = 0; f_seen = 0;
    end
    e_lk = m_lk;
  endtask

  // Compare process: outputs checked 1 time unit after every active edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("h_total",   int'(h_total),   e_ht);
      check("h_active",  int'(h_active),  e_ha);
      check("v_total",   int'(v_total),   e_vt);
      check("v_active",  int'(v_active),  e_va);
      check("locked",    int'(locked),    int'(e_lk));
      check("de",        int'(de),        int'(e_de));
      check("x",         int'(x),         e_x);
      check("y",         int'(y),         e_y);
      check("frame_cnt", int'(frame_cnt), e_fc);
      check("crc",       int'(crc),       e_crc);
    end
  end

  task automatic step(input bit rst, input bit ce, input bit hs, input bit hb, input bit vs,
                      input bit vb, input logic [7:0] v);
    @(posedge clk);
    #2;
    reset = rst; ce_pix = ce; HSync = hs; HBlank = hb; VSync = vs; VBlank = vb; video = v;
    if (rst || ce) model(rst, hs, hb, vs, vb, v);
    chk_en = 1'b1;
  endtask

  task automatic pix(input int col, input int row);
    logic [7:0] v;
    v = rnd_vid ? 8'($urandom) : 8'h00;
    step(1'b0, 1'b1, (col >= 85 && col <= 89), (col >= 80), (row == 17), (row >= 16), v);
  endtask

  task automatic line(input int row, input bit extra);
    for (int c = 0; c < 100; c++) pix(c, row);
    if (extra) pix(100, row);
  endtask

  task automatic frame();
    for (int r = 0; r < 20; r++) line(r, 1'b0);
  endtask

  initial begin
    step(1'b1, 1'b0, 0, 0, 0, 0, 8'h00);
    step(1'b1, 1'b0, 0, 0, 0, 0, 8'h00);
    step(1'b0, 1'b0, 0, 0, 0, 0, 8'h00);
    check("rst_h_total", int'(h_total), 0);
    check("rst_locked",  int'(locked),  0);

    // Two frames of zero video: geometry reported after the 2nd VSync rise.
    frame();
    frame();
    check("f1_h_total",   int'(h_total),   100);
    check("f1_h_active",  int'(h_active),  80);
    check("f1_v_total",   int'(v_total),   20);
    check("f1_v_active",  int'(v_active),  16);
    check("f1_locked",    int'(locked),    0);
    check("f1_frame_cnt", int'(frame_cnt), 1);

    rnd_vid = 1'b1;
    frame();
    check("f2_locked",    int'(locked),    1);
    check("f2_frame_cnt", int'(frame_cnt), 2);

    // Frame with one 101-sample line drops lock at the following HSync rise.
    for (int r = 0; r < 20; r++) begin
      line(r, r == 5);
      if (r == 6) begin
        check("long_h_total", int'(h_total), 101);
        check("long_locked",  int'(locked),  0);
      end
    end
    frame();
    check("f4_locked",    int'(locked),    0);
    check("f4_frame_cnt", int'(frame_cnt), 3);
    frame();
    check("relock",       int'(locked),    1);
    check("f5_frame_cnt", int'(frame_cnt), 4);

    // HSync held low for 5000 samples with ce_pix alternating: hcnt saturates.
    for (int i = 0; i < 10000; i++) step(1'b0, i[0], 0, 0, 0, 0, 8'h00);
    check("sat_locked",  int'(locked),  0);
    check("sat_h_total", int'(h_total), 100);
    step(1'b0, 1'b1, 1, 0, 0, 0, 8'h00);
    step(1'b0, 1'b1, 0, 0, 0, 0, 8'h00);
    step(1'b0, 1'b1, 0, 0, 0, 0, 8'h00);
    check("sat_next_h_total", int'(h_total), 100);

    // Reset asserted mid-line.
    for (int r = 0; r < 3; r++) line(r, 1'b0);
    for (int c = 0; c < 40; c++) pix(c, 3);
    step(1'b1, 1'b1, 0, 0, 0, 0, 8'h00);
    step(1'b0, 1'b0, 0, 0, 0, 0, 8'h00);
    check("mrst_h_total",   int'(h_total),   0);
    check("mrst_v_total",   int'(v_total),   0);
    check("mrst_frame_cnt", int'(frame_cnt), 0);
    check("mrst_x",         int'(x),         0);
    line(0, 1'b0);
    check("post_rst_h_total", int'(h_total), 0);
    line(1, 1'b0);
    check("post_rst_h_total2", int'(h_total), 100);
    for (int r = 2; r < 20; r++) line(r, 1'b0);
    frame();
    frame();
    check("end_locked", int'(locked), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_sync_analyzer.md
# video_sync_analyzer

Receive-side companion to the core's video timing generators. It samples the pixel-rate sync/blank/video outputs (ce_pix, HSync, HBlank, VSync, VBlank, video) and measures line and frame geometry, tracks lock, and produces active-area pixel coordinates. It sits on the core's video output next to the scaler input, and serves as a debug probe and as a bench checker for generator changes.

## Interface
- HW, 12, width of horizontal counters/measurements
- VW, 11, width of vertical counters/measurements
- LOCK_FRAMES, 2, consecutive identical frames required to enter LOCKED (1..7)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce_pix  in  1  pixel enable; all inputs are sampled only when ce_pix=1
- HSync, HBlank, VSync, VBlank  in  1 each  active-high timing inputs
- video  in  8  pixel value
- h_total  out  HW  ce_pix samples per line (last complete line)
- h_active  out  HW  samples with HBlank=0 in last complete line
- v_total  out  VW  lines per frame (last complete frame)
- v_active  out  VW  lines of last frame whose HSync rise sampled VBlank=0
- locked  out  1  geometry stable
- de  out  1  registered ~HBlank & ~VBlank of current sample
- x  out  HW  active pixel index in line; y  out  VW  active line index
- frame_cnt  out  16  completed frames, wraps
- crc  out  16  per-frame CRC (see Configuration)

## Operation
- Edge detection on sampled values: rise = current 1, previous sample 0. Previous-sample registers reset to 1 (no false edge after reset).
- hcnt: +1 per sample, saturates at 2^HW-1. On HSync rise: if line_seen, h_total <= hcnt+1; hcnt <= 0; line_seen <= 1.
- hact: +1 per sample with HBlank=0; latched to h_active and cleared on HSync rise (same rule as h_total).
- vcnt/vact: on HSync rise vcnt+1 (vact+1 if VBlank=0), saturating. On VSync rise (evaluated after HSync rise of the same sample, so a coincident line counts toward closing frame): if frame_seen, v_total <= vcnt', v_active <= vact', frame_cnt+1; counters <= 0; frame_seen <= 1.
- x: cleared on HBlank rise, +1 per sample with de. y: cleared on VSync rise, +1 on HBlank rise when VBlank=0.
- Lock FSM: UNLOCKED -> MEASURE on first complete frame (stores h_total/v_total as reference, match=1). MEASURE: each frame end compares; equal -> match+1, LOCKED when match==LOCK_FRAMES; differ -> reload reference, match=1. LOCKED: any line h_total != reference, any frame v_total != reference, or hcnt saturation -> UNLOCKED (also clears line_seen/frame_seen). locked=1 only in LOCKED.

## Timing
- All outputs registered; update one clk after the ce_pix sample that causes them. ce_pix=0 cycles hold all state.
- Reset: every output 0, FSM UNLOCKED, counters 0, seen flags 0; takes effect on the cycle reset is high, mid-frame included. First partial line/frame after reset or unlock is never reported.
- Saturated measurements report 2^W-1; never wrap.
- h_total/h_active may change in LOCKED only by dropping lock in the same update.

## Configuration
- VIDEO_SYNC_ANALYZER_CRC_EN defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first, no final XOR) over video of every sample with de=1; latched to crc and reinitialised on VSync rise (after frame_seen), one byte per sample.
- Undefined: no CRC logic; crc tied to 0.

## Test plan
- Synthetic 100x20 frame, ce_pix every cycle, HBlank high samples 80..99, HSync 85..89, VBlank lines 16..19, VSync line 17 -> after 2nd VSync rise h_total=100, h_active=80, v_total=20, v_active=16.
- Same stimulus, LOCK_FRAMES=2 -> locked rises one clk after 3rd frame end; frame_cnt=2 at that point.
- While locked, one line with 101 samples -> locked=0 one clk after that HSync rise; relocks after 3 further clean frames.
- ce_pix alternating, HSync held low 5000 samples -> h_total stays, hcnt saturates 4095, locked=0; next HSync rise does not update h_total.
- Reset asserted mid-line -> all outputs 0 next cycle; first post-reset HSync rise leaves h_total=0.
- With CRC_EN, constant video=0x00 over 80x16 active -> crc equals model CRC of 1280 zero bytes; without it crc=0.
